dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder for the pipelined ARM core's memory-stage interface.
//  Serves the core's load/store requests (MemRead/MemWrite, ALUResult address, WriteData)
//  from an internal word RAM with programmable wait states. Returns ReadData and a
//  MemStall hold signal so the core freezes its pipeline while an access is in flight.
// PARAMETERS
//  DEPTH        64            number of 32-bit words; power of two, 4..4096
//  WAIT_STATES  1             extra busy cycles per access, 0..15
//  MMIO_ADDR    32'hFFFF_FFFC byte address of cycle-counter register (DMEM_MMIO_EN only)
// PORTS
//  clk        in   1   single clock, all state on rising edge
//  reset      in   1   asynchronous, active-low reset
//  MemRead    in   1   load request, held stable while MemStall=1
//  MemWrite   in   1   store request, held stable while MemStall=1
//  ALUResult  in   32  byte address of access
//  WriteData  in   32  store data
//  ReadData   out  32  load data, registered, valid in DONE cycle, held until next DONE
//  MemStall   out  1   combinational; 1 = core must hold M-stage request
//  AddrErr    out  1   registered; 1-cycle pulse in DONE cycle of a faulting access
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, wait counter=0, ReadData=0, AddrErr=0,
//    MMIO counter=0. RAM contents not cleared (X in sim). In-flight access aborted, no write.
//  - req = MemRead|MemWrite. MemStall = req & (state!=DONE).
//  - FSM: IDLE: req -> (WAIT_STATES==0 ? DONE : BUSY, cnt=WAIT_STATES-1); else IDLE.
//         BUSY: !req -> IDLE (abort, no write, ReadData unchanged);
//               cnt==0 -> DONE; else cnt-=1.
//         DONE: -> IDLE unconditionally (core advances on this edge).
//  - Access commits on the edge entering DONE: store writes RAM[ALUResult[AW+1:2]],
//    AW=log2(DEPTH); load latches RAM word into ReadData.
//  - Latency: WAIT_STATES+2 cycles from request to DONE; MemStall high WAIT_STATES+1 cycles.
//  - Back-to-back: DONE->IDLE costs one cycle; a new request in IDLE starts immediately.
//  - MemRead&MemWrite both 1: write performed; ReadData gets pre-write word (read-before-write).
//  - Fault = ALUResult[1:0]!=0, or ALUResult[31:AW+2]!=0 (out of range) and not MMIO hit.
//    Fault: write suppressed, ReadData<=0, AddrErr=1 in DONE cycle. Still completes normally.
//  - Word accesses only; no byte enables.
// CONFIGURATION
//  - DMEM_MMIO_EN defined: 32-bit free-running cycle counter, +1 every clk, wraps
//    0xFFFF_FFFF->0. Load at MMIO_ADDR returns counter value sampled on DONE-entry edge;
//    store at MMIO_ADDR loads counter with WriteData (counter continues from WriteData+1
//    next cycle). MMIO hit is not a fault.
//  - DMEM_MMIO_EN undefined: no counter logic; MMIO_ADDR is out of range -> AddrErr.
// TESTING
//  - Reset: drive reset=0 mid-BUSY of store 0xDEAD_BEEF@0x10 -> ReadData=0, AddrErr=0,
//    MemStall follows req; later load @0x10 does not return 0xDEAD_BEEF.
//  - WAIT_STATES=2: store 0x1234_5678@0x08 then load @0x08 -> MemStall high 3 cycles each,
//    ReadData=0x1234_5678 in load's DONE cycle, held after.
//  - WAIT_STATES=0: 4 back-to-back loads -> each completes 2 cycles after request, stall 1.
//  - Misaligned store @0x0A and out-of-range load @(DEPTH*4) -> AddrErr pulse 1 cycle,
//    RAM unchanged, ReadData=0.
//  - MemRead=MemWrite=1 @0x04 (old 0x11, new 0x22) -> ReadData=0x11, subsequent load 0x22.
//  - DMEM_MMIO_EN: store 0xFFFF_FFF0 @MMIO_ADDR, load 20 cycles later -> value wrapped
//    past 0 (small value consistent with cycle count); without macro -> AddrErr=1.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with programmable wait states and a MemStall hold.
// Optional free-running cycle-counter register at MMIO_ADDR when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] MMIO_ADDR   = 32'hFFFF_FFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemStall,
    output logic        AddrErr
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem_q [DEPTH];

    logic          req;
    logic          commit;
    logic          in_range;
    logic          mmio_hit;
    logic          fault;
    logic [AW-1:0] idx;
    logic [31:0]   mmio_rdata;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
    logic [31:0] cyc_cnt_q;

    // Free-running counter; a store to MMIO_ADDR reloads it on the commit edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt_q <= '0;
        end else if (commit && mmio_hit && MemWrite && !fault) begin
            cyc_cnt_q <= WriteData;
        end else begin
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
        end
    end

    assign mmio_rdata = cyc_cnt_q;
`else
    localparam bit MMIO_EN = 1'b0;
    assign mmio_rdata = '0;
`endif

    assign req      = MemRead | MemWrite;
    assign MemStall = req & (state_q != DONE);
    assign idx      = ALUResult[AW+1:2];
    assign in_range = (ALUResult >> (AW + 2)) == 32'd0;
    assign mmio_hit = MMIO_EN && (ALUResult == MMIO_ADDR);
    assign fault    = (ALUResult[1:0] != 2'b00) || (!in_range && !mmio_hit);

    // The edge that enters DONE is the one that performs the access
    assign commit = reset && req &&
                    (((state_q == IDLE) && (WAIT_STATES == 0)) ||
                     ((state_q == BUSY) && (cnt_q == '0)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(WAIT_STATES - 1);
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (commit) begin
                if (fault) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (MemRead) begin
                    rdata_q <= mmio_hit ? mmio_rdata : mem_q[idx];
                end
            end
        end
    end

    // RAM is never cleared; the read above sees the pre-write word
    always_ff @(posedge clk) begin
        if (commit && MemWrite && !fault && !mmio_hit) begin
            mem_q[idx] <= WriteData;
        end
    end

    assign ReadData = rdata_q;
    assign AddrErr  = err_q;

endmodule
